// File: rtl/ifu_mem_responder.sv
// Instruction-memory responder for the fetch side of the core.
// Accepts one fetch at a time over a valid/ready request channel and returns
// the instruction word, or a fault, a fixed number of cycles later over a
// valid/ready response channel. The word store is preloaded via the load port.
module ifu_mem_responder #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] BASE    = 32'h8000_0000,
  parameter int               DEPTH   = 1024,
  parameter int               LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic [31:0]      rsp_count
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);
  localparam logic [3:0]       LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_err_reg;
  logic [31:0]      rsp_count_reg;

  // Instruction store; deliberately not reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             rd_fire;
  logic             rsp_hs;
  logic [WIDTH-1:0] rd_addr, rd_off, ld_off;
  logic             rd_bad, ld_bad;
  logic [AW-1:0]    rd_idx, ld_idx;

  // With a single-cycle latency the read happens at the acceptance edge,
  // so the live request address is used in IDLE; otherwise the captured one.
  assign rd_addr = (state_reg == IDLE) ? req_addr : addr_reg;

  // Byte-address to word-index decode, shared shape for fetch and load.
  assign rd_off = rd_addr - BASE;
  assign rd_bad = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE) || ((rd_off >> 2) >= DEPTH_W);
  assign rd_idx = rd_off[AW+1:2];

  assign ld_off = load_addr - BASE;
  assign ld_bad = (load_addr[1:0] != 2'b00) || (load_addr < BASE) || ((ld_off >> 2) >= DEPTH_W);
  assign ld_idx = ld_off[AW+1:2];

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    rd_fire    = 1'b0;
    rsp_hs     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY > 1) begin
            cnt_next   = LAT_INIT;
            state_next = WAIT;
          end else begin
            cnt_next   = 4'd0;
            rd_fire    = 1'b1;
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          cnt_next   = 4'd0;
          rd_fire    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the fetch address at acceptance for the delayed read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_reg <= '0;
    end else if (accept) begin
      addr_reg <= req_addr;
    end
  end

  // Registered store read; faults return zero and skip the store entirely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else if (rd_fire) begin
      rsp_err_reg  <= rd_bad;
      rsp_data_reg <= rd_bad ? '0 : mem[rd_idx];
    end
  end

  // Loader write; a same-edge read sees the previous word (read-before-write).
  always_ff @(posedge clk) begin
    if (load_en && !ld_bad) begin
      mem[ld_idx] <= load_data;
    end
  end

  // Completed response handshakes, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_count_reg <= 32'd0;
    end else if (rsp_hs) begin
      rsp_count_reg <= rsp_count_reg + 32'd1;
    end
  end

  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_count = rsp_count_reg;

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Directed bench for ifu_mem_responder at default parameters (LATENCY=2).
module tb_ifu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] rsp_count;

  int          checks    = 0;
  int          failures  = 0;
  logic [31:0] exp_count = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  ifu_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rsp_count (rsp_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
    $display("load addr=%h data=%h", addr, data);
  endtask

  // One full fetch with rsp_ready high: accept, one WAIT cycle, RESP, handshake.
  task automatic fetch(input logic [31:0] addr, input logic exp_err,
                       input logic [31:0] exp_data, input string tag);
    chk({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid_wait"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd0);
    tick();
    chk({tag, "_valid_resp"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    $display("fetch addr=%h data=%h err=%b", addr, rsp_data, rsp_err);
    tick();
    exp_count++;
    chk({tag, "_valid_after"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_count"}, rsp_count, exp_count);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 1'b0, 32'h0000_0413};
    vecs[1] = '{32'h8000_0004, 1'b0, 32'h0000_0513};
    vecs[2] = '{32'h8000_0008, 1'b0, 32'h0000_0613};
    vecs[3] = '{32'h8000_000C, 1'b0, 32'h0000_0713};
    vecs[4] = '{32'h8000_0FFC, 1'b0, 32'h0000_0073};
    vecs[5] = '{32'h8000_0002, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'h8000_1000, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'h7FFF_FFFC, 1'b1, 32'h0000_0000};
    vecs[8] = '{32'h8000_0001, 1'b1, 32'h0000_0000};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    rsp_ready = 1'b1;
    load_en   = 1'b0;
    load_addr = 32'd0;
    load_data = 32'd0;
    tick();
    tick();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_count", rsp_count, 32'd0);
    rst = 1'b1;
    tick();

    // Preload, then attempt loads that would alias onto good words if decoded wrongly.
    load_word(32'h8000_0000, 32'h0000_0413);
    load_word(32'h8000_0004, 32'h0000_0513);
    load_word(32'h8000_0008, 32'h0000_0613);
    load_word(32'h8000_000C, 32'h0000_0713);
    load_word(32'h8000_0FFC, 32'h0000_0073);
    load_word(32'h8000_1000, 32'hBAD0_0000);
    load_word(32'h8000_0006, 32'hBAD0_0001);
    load_word(32'h7FFF_FFFC, 32'hBAD0_0002);

    for (int i = 0; i < 9; i++) begin
      fetch(vecs[i].addr, vecs[i].exp_err, vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Back-to-back: second request held valid while the first is in flight.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    tick();
    req_addr  = 32'h8000_0004;
    chk("b2b_ready_wait1", {31'd0, req_ready}, 32'd0);
    chk("b2b_valid_wait1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("b2b_valid_resp1", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_data1", rsp_data, 32'h0000_0413);
    chk("b2b_ready_resp1", {31'd0, req_ready}, 32'd0);
    $display("fetch addr=80000000 data=%h err=%b (b2b)", rsp_data, rsp_err);
    tick();
    exp_count++;
    chk("b2b_valid_gap", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_ready_gap", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_ready_wait2", {31'd0, req_ready}, 32'd0);
    chk("b2b_valid_wait2", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("b2b_valid_resp2", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_data2", rsp_data, 32'h0000_0513);
    $display("fetch addr=80000004 data=%h err=%b (b2b)", rsp_data, rsp_err);
    tick();
    exp_count++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_no_extra%0d", i), {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("b2b_count", rsp_count, exp_count);

    // Backpressure: response held for five cycles with rsp_ready low.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_data", i), rsp_data, 32'h0000_0613);
      chk($sformatf("stall%0d_err", i), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("stall%0d_ready", i), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d_count", i), rsp_count, exp_count);
      tick();
    end
    rsp_ready = 1'b1;
    $display("fetch addr=80000008 data=%h err=%b (stalled)", rsp_data, rsp_err);
    tick();
    exp_count++;
    chk("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stall_release_count", rsp_count, exp_count);

    // Reset while a fetch sits in WAIT drops it; store survives.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    rst       = 1'b0;
    tick();
    rst       = 1'b1;
    exp_count = 32'd0;
    chk("rstwait_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstwait_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwait_count", rsp_count, 32'd0);
    chk("rstwait_data", rsp_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstwait_no_stale%0d", i), {31'd0, rsp_valid}, 32'd0);
    end
    fetch(32'h8000_0004, 1'b0, 32'h0000_0513, "post_reset");

    // Load to word 1 on the same edge the store read of word 1 happens.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'h8000_0004;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en   = 1'b0;
    chk("rbw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rbw_old_data", rsp_data, 32'h0000_0513);
    $display("fetch addr=80000004 data=%h err=%b (load same edge)", rsp_data, rsp_err);
    tick();
    exp_count++;
    chk("rbw_count", rsp_count, exp_count);
    fetch(32'h8000_0004, 1'b0, 32'hDEAD_BEEF, "rbw_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_mem_responder.md
# ifu_mem_responder

Instruction-memory responder on the fetch side of the CPU core. It accepts fetch requests (address) from the core's IFU over a valid/ready channel and returns the 32-bit instruction word over a second valid/ready channel after a fixed, parameterised latency. It holds a word-addressed instruction store starting at the reset PC base, with a bench/loader write port for preloading programs. It flags misaligned and out-of-range fetches.

## Interface
- WIDTH, 32, address and data width
- BASE, 32'h8000_0000, byte address of word 0 (matches the CPU reset PC)
- DEPTH, 1024, number of WIDTH-bit words in the store
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  WIDTH  fetch byte address
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts response
- rsp_data  output  WIDTH  instruction word
- rsp_err  output  1  fetch fault (misaligned or out of range)
- load_en  input  1  write one word into the store
- load_addr  input  WIDTH  byte address for load (same BASE/DEPTH mapping)
- load_data  input  WIDTH  word to write
- rsp_count  output  32  completed response handshakes, wraps at 2^32

## Operation
- States: IDLE, WAIT, RESP. Single outstanding transaction; no request overlap.
- IDLE: req_ready=1, rsp_valid=0. On req_valid&&req_ready, capture req_addr, load latency counter with LATENCY-1; go WAIT if LATENCY>1, else RESP.
- WAIT: req_ready=0. Counter decrements each cycle; when it reaches 0, perform the store read and go RESP.
- RESP: rsp_valid=1, req_ready=0; rsp_data/rsp_err held stable until rsp_valid&&rsp_ready. On handshake: rsp_count+1, go IDLE.
- Address decode: index=(addr-BASE)>>2. Error if addr[1:0]!=0, addr<BASE, or index>=DEPTH. On error rsp_err=1, rsp_data=0; no store access.
- Load port: on load_en with valid decoded load_addr, write store[index]=load_data. Misaligned or out-of-range loads are ignored silently. Load accepted in any state.
- Same-cycle load and read of the same word: read returns old contents (read-before-write).
- Store contents are not affected by reset; uninitialised words read as X in simulation (bench must preload).
- rsp_data/rsp_err are registered; they change only when entering RESP.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, req_ready=1 in the following cycle, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_count=0, latency counter=0. Reset asserted in WAIT or RESP drops the transaction without a response.
- Request accepted at edge T -> rsp_valid high from cycle T+LATENCY (LATENCY=1: rsp_valid in the cycle immediately after acceptance).
- rsp_ready held high: handshake at the first rsp_valid cycle; req_ready returns high the next cycle; peak throughput one fetch per LATENCY+1 cycles.
- rsp_ready low: rsp_valid, rsp_data and rsp_err held indefinitely; no new request accepted.
- req_valid while req_ready=0 is ignored; the requester must hold it (standard valid/ready: valid must not drop before handshake).
- rsp_count increments in the cycle after the handshake edge; 32'hFFFF_FFFF+1 -> 0.

## Test plan
- Preload store[0]=32'h0000_0413, store[1]=32'h0000_0513 via load port; LATENCY=2, rsp_ready=1, request 32'h8000_0000 at T -> rsp_valid at T+2 with rsp_data=32'h0000_0413, rsp_err=0; req_ready high at T+3; rsp_count=1.
- Back-to-back fetches 0x8000_0000 and 0x8000_0004 with req_valid held high -> second accepted at T+3, response at T+5 = 32'h0000_0513; exactly one response per request.
- rsp_ready low for 5 cycles after rsp_valid -> rsp_data/rsp_err stable, req_ready=0 throughout, rsp_count unchanged until handshake.
- Fetch 0x8000_0002 -> rsp_err=1, rsp_data=0; fetch BASE+4*DEPTH and 0x7FFF_FFFC -> rsp_err=1; load to out-of-range address leaves the store unchanged.
- Assert rst=0 during WAIT -> next cycle rsp_valid=0, req_ready=1, rsp_count=0; no stale response ever appears; preloaded contents still readable afterwards.
- load_en to word 1 with 32'hDEAD_BEEF in the same cycle as the store read of word 1 -> response returns old value 32'h0000_0513; a subsequent fetch returns 32'hDEAD_BEEF.
